// File: rtl/tri_pkg.sv
// Shared types for the triangle batch scheduler: fixed-point t type, its
// limit constants and the scheduler state encoding.
package tri_pkg;

  localparam int unsigned FIP_W    = 32;
  localparam int unsigned FIP_FRAC = 16;

  // Q16.16 signed fixed-point ray distance
  typedef logic signed [FIP_W-1:0] fip_t;

  localparam fip_t FIP_ONE = 32'sh0001_0000;
  localparam fip_t FIP_MAX = 32'sh7fff_ffff;
  localparam fip_t FIP_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/hit_min_tree.sv
// Combinational LANES-way qualify-and-min reduction. A lane qualifies when it
// is valid, reports a hit and has non-negative t. The smallest signed t wins;
// equal t resolves to the lower triangle index regardless of lane position.
module hit_min_tree
  import tri_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned T_W   = 32,
  parameter int unsigned IDX_W = 32
) (
  input  logic [LANES-1:0]       i_valid,
  input  logic [LANES-1:0]       i_hit,
  input  logic [LANES*T_W-1:0]   i_t,
  input  logic [LANES*IDX_W-1:0] i_idx,
  output logic                   o_hit,
  output logic [T_W-1:0]         o_t,
  output logic [IDX_W-1:0]       o_idx
);

  localparam logic [T_W-1:0] T_MAX = {1'b0, {(T_W-1){1'b1}}};

  logic             best_hit;
  logic [T_W-1:0]   best_t;
  logic [IDX_W-1:0] best_idx;
  logic [T_W-1:0]   lane_t;
  logic [IDX_W-1:0] lane_idx;
  logic             lane_q;

  // Fold every lane into the running best candidate
  always_comb begin
    best_hit = 1'b0;
    best_t   = T_MAX;
    best_idx = '0;
    lane_t   = '0;
    lane_idx = '0;
    lane_q   = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_t   = i_t[i*T_W +: T_W];
      lane_idx = i_idx[i*IDX_W +: IDX_W];
      lane_q   = i_valid[i] & i_hit[i] & ~lane_t[T_W-1];
      if (lane_q && (!best_hit ||
                     ($signed(lane_t) < $signed(best_t)) ||
                     ((lane_t == best_t) && (lane_idx < best_idx)))) begin
        best_hit = 1'b1;
        best_t   = lane_t;
        best_idx = lane_idx;
      end
    end
  end

  assign o_hit = best_hit;
  assign o_t   = best_t;
  assign o_idx = best_idx;

endmodule

// File: rtl/tri_batch_sched.sv
// Triangle batch scheduler: issues triangle fetch indices in descending order,
// bounds outstanding fetches, and min-reduces returning intersection results
// into a closest-hit {hit, t, index} record.
// Optional any-hit (shadow) mode is compiled in with TRI_SCHED_ANYHIT_EN.
module tri_batch_sched
  import tri_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned T_W     = 32,
  parameter int unsigned IDX_W   = 32,
  parameter int unsigned MAX_OUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [IDX_W-1:0]       i_tri_cnt,
`ifdef TRI_SCHED_ANYHIT_EN
  input  logic                   i_anyhit,
`endif
  output logic                   o_busy,
  output logic                   o_rd_req,
  output logic [IDX_W-1:0]       o_rd_idx,
  input  logic                   i_rd_ready,
  input  logic [LANES-1:0]       i_res_valid,
  input  logic [LANES-1:0]       i_res_hit,
  input  logic [LANES*T_W-1:0]   i_res_t,
  input  logic [LANES*IDX_W-1:0] i_res_idx,
  output logic                   o_hit,
  output logic [T_W-1:0]         o_t,
  output logic [IDX_W-1:0]       o_tri_index,
  output logic                   o_finish
);

  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam int unsigned IF_W  = $clog2(MAX_OUT) + 1;
  localparam logic [T_W-1:0] T_MAX = {1'b0, {(T_W-1){1'b1}}};

  sched_state_e     state_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] issued_q;
  logic [IDX_W-1:0] returned_q;
  logic [IF_W-1:0]  inflight_q;
  logic [IF_W-1:0]  inflight_d;
  logic             rd_req_q;
  logic             busy_q;
  logic             finish_q;

  logic             hit_q;
  logic [T_W-1:0]   t_q;
  logic [IDX_W-1:0] idx_q;

  logic             red_busy_q;
  logic             red_hit_q;
  logic [T_W-1:0]   red_t_q;
  logic [IDX_W-1:0] red_idx_q;

  logic             active_c;
  logic             start_c;
  logic             fire_c;
  logic             stop_c;
  logic             better_c;
  logic [LANES-1:0] res_vld_c;
  logic [CNT_W-1:0] pop_c;
  logic             tree_hit_c;
  logic [T_W-1:0]   tree_t_c;
  logic [IDX_W-1:0] tree_idx_c;

  assign active_c  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign start_c   = (state_q == ST_IDLE) && i_start;
  assign fire_c    = rd_req_q && i_rd_ready;
  assign res_vld_c = i_res_valid & {LANES{active_c}};

  // Number of results returning this cycle
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      pop_c = pop_c + CNT_W'(res_vld_c[i]);
    end
  end

  assign inflight_d = inflight_q + IF_W'(fire_c) - IF_W'(pop_c);

`ifdef TRI_SCHED_ANYHIT_EN
  logic anyhit_q;

  // Any-hit mode is latched per batch at start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anyhit_q <= 1'b0;
    end else if (start_c) begin
      anyhit_q <= i_anyhit;
    end
  end

  assign stop_c = anyhit_q && red_hit_q;
`else
  assign stop_c = 1'b0;
`endif

  hit_min_tree #(
    .LANES (LANES),
    .T_W   (T_W),
    .IDX_W (IDX_W)
  ) u_hit_min_tree (
    .i_valid (res_vld_c),
    .i_hit   (i_res_hit),
    .i_t     (i_res_t),
    .i_idx   (i_res_idx),
    .o_hit   (tree_hit_c),
    .o_t     (tree_t_c),
    .o_idx   (tree_idx_c)
  );

  // Register the per-cycle lane reduction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_busy_q <= 1'b0;
      red_hit_q  <= 1'b0;
      red_t_q    <= T_MAX;
      red_idx_q  <= '0;
    end else begin
      red_busy_q <= |res_vld_c;
      red_hit_q  <= tree_hit_c;
      red_t_q    <= tree_t_c;
      red_idx_q  <= tree_idx_c;
    end
  end

  assign better_c = red_hit_q &&
                    (!hit_q ||
                     ($signed(red_t_q) < $signed(t_q)) ||
                     ((red_t_q == t_q) && (red_idx_q < idx_q)));

  // Closest-hit accumulator, cleared at batch start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b0;
      t_q   <= T_MAX;
      idx_q <= '0;
    end else if (start_c) begin
      hit_q <= 1'b0;
      t_q   <= T_MAX;
      idx_q <= '0;
    end else if (better_c) begin
      hit_q <= 1'b1;
      t_q   <= red_t_q;
      idx_q <= red_idx_q;
    end
  end

  // Batch control FSM with issue/return bookkeeping and registered handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_idx_q   <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      inflight_q <= '0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            issued_q   <= '0;
            returned_q <= '0;
            inflight_q <= '0;
            if (i_tri_cnt != '0) begin
              state_q  <= ST_ISSUE;
              rd_idx_q <= i_tri_cnt - IDX_W'(1);
              rd_req_q <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q  <= ST_DONE;
              finish_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          inflight_q <= inflight_d;
          returned_q <= returned_q + IDX_W'(pop_c);
          if (fire_c) begin
            issued_q <= issued_q + IDX_W'(1);
            if (rd_idx_q != '0) begin
              rd_idx_q <= rd_idx_q - IDX_W'(1);
            end
          end
          if ((fire_c && (rd_idx_q == '0)) || stop_c) begin
            state_q  <= ST_DRAIN;
            rd_req_q <= 1'b0;
          end else begin
            rd_req_q <= (inflight_d < IF_W'(MAX_OUT));
          end
        end
        ST_DRAIN: begin
          inflight_q <= inflight_d;
          returned_q <= returned_q + IDX_W'(pop_c);
          if ((returned_q == issued_q) && !red_busy_q) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_rd_req    = rd_req_q;
  assign o_rd_idx    = rd_idx_q;
  assign o_hit       = hit_q;
  assign o_t         = t_q;
  assign o_tri_index = idx_q;
  assign o_finish    = finish_q;

endmodule

// File: tb/tb_tri_batch_sched.sv
// Directed bench for tri_batch_sched: a result responder that answers issued
// fetches from a per-index hit table, a closest-hit model fed by the same
// results, and per-cycle protocol checks plus hand-computed end results.
module tb_tri_batch_sched;

  localparam int LANES   = 4;
  localparam int T_W     = 32;
  localparam int IDX_W   = 32;
  localparam int MAX_OUT = 16;
  localparam logic [31:0] TMAX = 32'h7fff_ffff;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   i_start = 1'b0;
  logic [IDX_W-1:0]       i_tri_cnt = '0;
`ifdef TRI_SCHED_ANYHIT_EN
  logic                   i_anyhit = 1'b0;
`endif
  logic                   o_busy;
  logic                   o_rd_req;
  logic [IDX_W-1:0]       o_rd_idx;
  logic                   i_rd_ready = 1'b0;
  logic [LANES-1:0]       i_res_valid = '0;
  logic [LANES-1:0]       i_res_hit = '0;
  logic [LANES*T_W-1:0]   i_res_t = '0;
  logic [LANES*IDX_W-1:0] i_res_idx = '0;
  logic                   o_hit;
  logic [T_W-1:0]         o_t;
  logic [IDX_W-1:0]       o_tri_index;
  logic                   o_finish;

  int vectors = 0;
  int miscompares = 0;

  // Per-index result table and responder state
  logic        tbl_hit [0:127];
  logic [31:0] tbl_t   [0:127];
  int          pend_q[$];
  int          fires = 0;
  int          returned = 0;
  int          exp_idx = 0;
  int          finishes = 0;
  int          resp_lanes = 1;
  int          resp_budget = -1;
  int          ready_mode = 0;
  int          cyc = 0;
  bit          resp_en = 1'b0;
  bit          in_batch = 1'b0;
  bit          prev_req = 1'b0;
  bit          prev_ready = 1'b0;
  logic [31:0] prev_idx = '0;

  // Closest-hit model
  bit m_hit = 1'b0;
  int m_t = 32'h7fff_ffff;
  int m_idx = 0;

  tri_batch_sched #(
    .LANES   (LANES),
    .T_W     (T_W),
    .IDX_W   (IDX_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_tri_cnt   (i_tri_cnt),
`ifdef TRI_SCHED_ANYHIT_EN
    .i_anyhit    (i_anyhit),
`endif
    .o_busy      (o_busy),
    .o_rd_req    (o_rd_req),
    .o_rd_idx    (o_rd_idx),
    .i_rd_ready  (i_rd_ready),
    .i_res_valid (i_res_valid),
    .i_res_hit   (i_res_hit),
    .i_res_t     (i_res_t),
    .i_res_idx   (i_res_idx),
    .o_hit       (o_hit),
    .o_t         (o_t),
    .o_tri_index (o_tri_index),
    .o_finish    (o_finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Fetch-ready pattern: always ready, or ready two cycles out of three
  always @(posedge clk) begin
    #1;
    cyc++;
    i_rd_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) != 0);
  end

  // Compare process, result responder and handshake monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (o_finish) begin
        check("finish_in_batch", 64'(in_batch), 64'(1));
        check("busy_low_at_finish", 64'(o_busy), 64'(0));
        finishes++;
        in_batch = 1'b0;
      end
      if (o_rd_req)
        check("req_allowed", 64'(in_batch && ((fires - returned) < MAX_OUT)), 64'(1));
      if (prev_req && !prev_ready && o_rd_req)
        check("rd_idx_stable", 64'(o_rd_idx), 64'(prev_idx));

      i_res_valid = '0;
      i_res_hit   = '0;
      i_res_t     = '0;
      i_res_idx   = '0;
      if (resp_en) begin
        for (int n = 0; n < resp_lanes; n++) begin
          if (pend_q.size() > 0 && resp_budget != 0) begin
            int idx;
            int tt;
            idx = pend_q.pop_front();
            tt  = int'($signed(tbl_t[idx]));
            i_res_valid[n] = 1'b1;
            i_res_hit[n]   = tbl_hit[idx];
            i_res_t[n*T_W +: T_W]       = tbl_t[idx];
            i_res_idx[n*IDX_W +: IDX_W] = 32'(idx);
            returned++;
            if (resp_budget > 0) resp_budget--;
            if (tbl_hit[idx] && tt >= 0 &&
                (!m_hit || tt < m_t || (tt == m_t && idx < m_idx))) begin
              m_hit = 1'b1;
              m_t   = tt;
              m_idx = idx;
            end
          end
        end
      end

      if (o_rd_req && i_rd_ready) begin
        check("rd_idx_order", 64'(o_rd_idx), 64'(exp_idx));
        pend_q.push_back(int'(o_rd_idx));
        fires++;
        exp_idx--;
      end
      prev_req   = o_rd_req;
      prev_ready = i_rd_ready;
      prev_idx   = o_rd_idx;
    end
  end

  task automatic clear_tbl();
    for (int i = 0; i < 128; i++) begin
      tbl_hit[i] = 1'b0;
      tbl_t[i]   = 32'h0;
    end
  endtask

  task automatic start_batch(input int cnt);
    @(posedge clk); #1;
    i_start   = 1'b1;
    i_tri_cnt = 32'(cnt);
    m_hit     = 1'b0;
    m_t       = 32'h7fff_ffff;
    m_idx     = 0;
    fires     = 0;
    returned  = 0;
    exp_idx   = cnt - 1;
    finishes  = 0;
    pend_q.delete();
    @(posedge clk); #1;
    i_start  = 1'b0;
    in_batch = 1'b1;
  endtask

  task automatic wait_finish(input string name, input int budget);
    int n;
    n = 0;
    while (finishes == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_finish_seen"}, 64'(finishes > 0), 64'(1));
  endtask

  task automatic check_model(input string name);
    check({name, "_hit"}, 64'(o_hit), 64'(m_hit));
    check({name, "_t"}, 64'(o_t), 64'(32'(m_t)));
    check({name, "_idx"}, 64'(o_tri_index), 64'(32'(m_idx)));
    check({name, "_drained"}, 64'(returned), 64'(fires));
    // Final values hold and o_finish does not repeat
    repeat (3) @(negedge clk);
    #1;
    check({name, "_single_finish"}, 64'(finishes), 64'(1));
    check({name, "_t_hold"}, 64'(o_t), 64'(32'(m_t)));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_busy"}, 64'(o_busy), 64'(0));
    check({name, "_req"}, 64'(o_rd_req), 64'(0));
    check({name, "_finish"}, 64'(o_finish), 64'(0));
    check({name, "_hit"}, 64'(o_hit), 64'(0));
    check({name, "_t"}, 64'(o_t), 64'(TMAX));
    check({name, "_idx"}, 64'(o_tri_index), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_tbl();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Empty batch goes straight to done
    start_batch(0);
    wait_finish("empty", 3);
    check("empty_hit", 64'(o_hit), 64'(0));
    check("empty_t", 64'(o_t), 64'(32'h7fff_ffff));
    check("empty_idx", 64'(o_tri_index), 64'(0));
    check("empty_no_issue", 64'(fires), 64'(0));
    check_model("empty");

    // Single lane: t=1.0 appears on idx 3 and idx 1, lower index wins
    clear_tbl();
    tbl_hit[4] = 1'b1; tbl_t[4] = 32'h0003_0000;
    tbl_hit[3] = 1'b1; tbl_t[3] = 32'h0001_0000;
    tbl_hit[2] = 1'b1; tbl_t[2] = 32'h0002_0000;
    tbl_hit[1] = 1'b1; tbl_t[1] = 32'h0001_0000;
    tbl_hit[0] = 1'b1; tbl_t[0] = 32'h0004_0000;
    resp_lanes = 1; resp_budget = -1; resp_en = 1'b1; ready_mode = 0;
    start_batch(5);
    wait_finish("five", 60);
    check("five_t", 64'(o_t), 64'(32'h0001_0000));
    check("five_idx", 64'(o_tri_index), 64'(1));
    check("five_hit", 64'(o_hit), 64'(1));
    check("five_issued", 64'(fires), 64'(5));
    check_model("five");

    // Four lanes in one cycle: ties on t=2.0 across lanes, negative t rejected
    clear_tbl();
    tbl_hit[7] = 1'b1; tbl_t[7] = 32'h0002_0000;
    tbl_hit[3] = 1'b1; tbl_t[3] = 32'h0002_0000;
    tbl_hit[5] = 1'b1; tbl_t[5] = 32'h0002_0000;
    tbl_hit[1] = 1'b1; tbl_t[1] = 32'hffff_0000;
    resp_lanes = 4; resp_en = 1'b0;
    start_batch(8);
    for (int n = 0; n < 40 && fires < 8; n++) begin
      @(negedge clk); #1;
    end
    check("lanes_all_issued", 64'(fires), 64'(8));
    pend_q.delete();
    pend_q.push_back(7); pend_q.push_back(3); pend_q.push_back(5); pend_q.push_back(1);
    pend_q.push_back(6); pend_q.push_back(4); pend_q.push_back(2); pend_q.push_back(0);
    resp_en = 1'b1;
    wait_finish("lanes", 40);
    check("lanes_t", 64'(o_t), 64'(32'h0002_0000));
    check("lanes_idx", 64'(o_tri_index), 64'(3));
    check("lanes_hit", 64'(o_hit), 64'(1));
    check_model("lanes");

    // Results withheld: issue stops at the outstanding limit
    clear_tbl();
    for (int i = 2; i < 40; i += 5) begin
      tbl_hit[i] = 1'b1;
      tbl_t[i]   = 32'(((i * 7) % 13) << 16);
    end
    tbl_hit[30] = 1'b1; tbl_t[30] = 32'h0001_0000;
    tbl_hit[9]  = 1'b1; tbl_t[9]  = 32'hfffb_0000;
    resp_lanes = 2; resp_budget = 0; resp_en = 1'b1;
    start_batch(40);
    repeat (10) @(negedge clk);
    // A start while busy must be ignored
    @(posedge clk); #1;
    i_start = 1'b1; i_tri_cnt = 32'd3;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("limit_issued", 64'(fires), 64'(MAX_OUT));
    check("limit_req_low", 64'(o_rd_req), 64'(0));
    resp_budget = 1;
    repeat (5) @(negedge clk);
    #1;
    check("limit_one_more", 64'(fires), 64'(MAX_OUT + 1));
    check("limit_req_low_again", 64'(o_rd_req), 64'(0));
    resp_budget = -1;
    wait_finish("limit", 400);
    check("limit_total", 64'(fires), 64'(40));
    check("limit_t", 64'(o_t), 64'(32'h0001_0000));
    check("limit_idx", 64'(o_tri_index), 64'(2));
    check_model("limit");

    // Reset in the middle of issue
    clear_tbl();
    for (int i = 40; i < 50; i++) begin
      tbl_hit[i] = 1'b1;
      tbl_t[i]   = 32'h0005_0000;
    end
    resp_lanes = 1; resp_en = 1'b1;
    start_batch(50);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    check("pre_reset_busy", 64'(o_busy), 64'(1));
    reset = 1'b1;
    in_batch = 1'b0;
    resp_en = 1'b0;
    pend_q.delete();
    finishes = 0;
    @(negedge clk);
    check_reset_vals("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("midreset_no_finish", 64'(finishes), 64'(0));

    // Restart with gapped ready and zero t as the closest hit
    clear_tbl();
    tbl_hit[11] = 1'b1; tbl_t[11] = 32'h0000_0000;
    tbl_hit[5]  = 1'b1; tbl_t[5]  = 32'h0000_8000;
    tbl_hit[0]  = 1'b1; tbl_t[0]  = 32'h0000_0000;
    tbl_hit[4]  = 1'b0; tbl_t[4]  = 32'h0000_0100;
    resp_lanes = 3; resp_en = 1'b1; ready_mode = 1;
    start_batch(12);
    wait_finish("restart", 120);
    check("restart_t", 64'(o_t), 64'(0));
    check("restart_idx", 64'(o_tri_index), 64'(0));
    check("restart_hit", 64'(o_hit), 64'(1));
    check("restart_issued", 64'(fires), 64'(12));
    check_model("restart");
    ready_mode = 0;

`ifdef TRI_SCHED_ANYHIT_EN
    // Any-hit: first qualifying hit stops issue, in-flight results drain
    clear_tbl();
    tbl_hit[97] = 1'b1; tbl_t[97] = 32'h0002_0000;
    resp_lanes = 1; resp_en = 1'b1;
    i_anyhit = 1'b1;
    start_batch(100);
    i_anyhit = 1'b0;
    wait_finish("anyhit", 400);
    check("anyhit_hit", 64'(o_hit), 64'(1));
    check("anyhit_idx", 64'(o_tri_index), 64'(97));
    check("anyhit_t", 64'(o_t), 64'(32'h0002_0000));
    check("anyhit_stopped", 64'(fires < 100), 64'(1));
    check("anyhit_min_issued", 64'(fires >= 3), 64'(1));
    check_model("anyhit");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
